sram_mem_responder: RTL



---
 rtl/sram_mem_responder.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/sram_mem_responder.sv
`default_nettype none
`timescale 1ns/1ps
// sram_mem_responder: serves 32-bit MEM-stage loads/stores as two 16-bit
// accesses to an asynchronous SRAM; ready low freezes the pipeline.
module sram_mem_responder #(
   parameter int unsigned WAIT_CYCLES = 2,
   parameter int unsigned MEM_BASE    = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_en,
   input  logic        rd_en,
   input  logic [31:0] address,
   input  logic [31:0] write_data,
   output logic [31:0] read_data,
   output logic        ready,
   output logic [17:0] sram_addr,
   output logic [15:0] sram_dq_out,
   input  logic [15:0] sram_dq_in,
   output logic        sram_dq_oe,
   output logic        sram_we_n,
   output logic        sram_oe_n
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOW  = 2'd1,
      S_HIGH = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam logic [3:0] C_LAST = 4'(WAIT_CYCLES - 1);

   state_t      r_state;
   state_t      w_next;
   logic [3:0]  r_cnt;
   logic        r_is_wr;
   logic [16:0] r_idx;
   logic [15:0] r_wdata_hi;
   logic [31:0] r_rdata;
   logic [17:0] r_addr;
   logic [15:0] r_dq;

   logic        w_req;
   logic        w_last;
   logic [16:0] w_idx;

   assign w_req  = rd_en | wr_en;
   assign w_last = (r_cnt == C_LAST);
   // Addresses below MEM_BASE wrap modulo 2^32 before truncation.
   assign w_idx  = 17'((address - MEM_BASE) >> 2);

   assign read_data   = r_rdata;
   assign sram_addr   = r_addr;
   assign sram_dq_out = r_dq;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next     = r_state;
      ready      = 1'b0;
      sram_we_n  = 1'b1;
      sram_oe_n  = 1'b1;
      sram_dq_oe = 1'b0;
      case (r_state)
         S_IDLE: begin
            ready = ~w_req;
            if (w_req) begin
               w_next = S_LOW;
            end
         end
         S_LOW: begin
            sram_we_n  = ~r_is_wr;
            sram_oe_n  = r_is_wr;
            sram_dq_oe = r_is_wr;
            if (w_last) begin
               w_next = S_HIGH;
            end
         end
         S_HIGH: begin
            sram_we_n  = ~r_is_wr;
            sram_oe_n  = r_is_wr;
            sram_dq_oe = r_is_wr;
            if (w_last) begin
               w_next = S_DONE;
            end
         end
         S_DONE: begin
            ready  = 1'b1;
            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Address and store data are loaded at phase entry so they stay stable
   // for the whole phase; read halves are sampled on the phase's last cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt      <= 4'd0;
         r_is_wr    <= 1'b0;
         r_idx      <= 17'd0;
         r_wdata_hi <= 16'd0;
         r_rdata    <= 32'd0;
         r_addr     <= 18'd0;
         r_dq       <= 16'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_cnt <= 4'd0;
               if (w_req) begin
                  r_is_wr    <= wr_en;
                  r_idx      <= w_idx;
                  r_wdata_hi <= write_data[31:16];
                  r_addr     <= {w_idx, 1'b0};
                  if (wr_en) begin
                     r_dq <= write_data[15:0];
                  end
               end
            end
            S_LOW: begin
               if (w_last) begin
                  r_cnt  <= 4'd0;
                  r_addr <= {r_idx, 1'b1};
                  if (r_is_wr) begin
                     r_dq <= r_wdata_hi;
                  end else begin
                     r_rdata[15:0] <= sram_dq_in;
                  end
               end else begin
                  r_cnt <= r_cnt + 4'd1;
               end
            end
            S_HIGH: begin
               if (w_last) begin
                  r_cnt <= 4'd0;
                  if (!r_is_wr) begin
                     r_rdata[31:16] <= sram_dq_in;
                  end
               end else begin
                  r_cnt <= r_cnt + 4'd1;
               end
            end
            default: r_cnt <= 4'd0;
         endcase
      end
   end

endmodule
`default_nettype wire
